enc_bcd_counter: RTL and testbench
==================================

# enc_bcd_counter

Parametrised successor to the Lab 2 encoder-to-BCD counter. It accumulates single-cycle `cw`/`ccw` strobes from the rotary-encoder decoder and, every `PULSES_PER_STEP` strobes in one direction, steps an N-digit packed-BCD count up or down. Saturating or wrapping range behaviour is set by parameter. It sits between the encoder quadrature decoder and the 7-segment display driver, and adds a synchronous clear, limit flags and a step strobe.

## Interface

Parameters:
- `NUM_DIGITS`, 2: number of BCD digits, range 1–8; count width is 4·NUM_DIGITS.
- `PULSES_PER_STEP`, 4: strobes per count step, range 1–255.
- `WRAP`, 0: 0 saturates at the limits; 1 wraps max→0 and 0→max.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `cw` input 1: clockwise strobe; each cycle it is high counts as one pulse.
- `ccw` input 1: counter-clockwise strobe; each cycle it is high counts as one pulse.
- `clear` input 1: synchronous clear of the count and both accumulators.
- `bcd_count` output 4·NUM_DIGITS: packed BCD, digit 0 in [3:0], registered.
- `step` output 2: one-cycle step strobe; `2'b01` = up step, `2'b10` = down step, `2'b00` = no step.
- `at_max` output 1: high when every digit is 9.
- `at_min` output 1: high when the count is 0.

## Operation

- Each direction has its own accumulator `acc_cw` / `acc_ccw`, width $clog2(PULSES_PER_STEP+1).
- Accumulator update in a cycle with `cw`=1 and `ccw`=0:
  - If `acc_cw` = PULSES_PER_STEP−1: `acc_cw`←0 and an up step is issued.
  - Otherwise `acc_cw` increments.
  - In both cases `acc_ccw`←0, because a direction reversal discards partial progress in the other direction.
- The `ccw` path is symmetric: it issues a down step and clears `acc_cw`.
- If `cw` and `ccw` are both 1 in the same cycle, both accumulators and the count hold. This is treated as decoder glitch rejection.
- Up step:
  - Digit 0 increments. Each digit equal to 9 that receives a carry becomes 0 and passes the carry to the next digit.
  - A carry out of the top digit means the count was at max. With WRAP=0 the count holds at all 9s. With WRAP=1 it becomes all 0s.
- Down step:
  - Digit 0 decrements. Each digit equal to 0 that receives a borrow becomes 9 and passes the borrow to the next digit.
  - A borrow out of the top digit means the count was 0. With WRAP=0 the count holds at 0. With WRAP=1 it becomes all 9s.
- `step` pulses on every issued step, including a saturated step where the count does not change.
- `clear` has priority over `cw`/`ccw`. It sets `bcd_count`←0 and both accumulators ←0, and `step`=00 in that cycle.
- No digit ever holds a non-BCD value (A–F).

## Timing

- Reset values: `bcd_count`=0, accumulators=0, `step`=00, `at_min`=1, `at_max`=0.
- Latency: the strobe that completes a step is sampled at edge k. `bcd_count` and `step` show the result after edge k.
- `step` is high for exactly one cycle per issued step.
- `at_max` and `at_min` are combinational decodes of the registered `bcd_count`.
- Back-to-back strobes are legal. With PULSES_PER_STEP=1, one step is issued per cycle.
- Reset asserted mid-accumulation clears everything immediately. The first step after release needs a full PULSES_PER_STEP strobes.

## Structure

- Shared package `enc_pkg`:
  - `typedef logic [3:0] bcd_digit_t`
  - `typedef enum logic [1:0] {STEP_NONE=2'b00, STEP_UP=2'b01, STEP_DN=2'b10} step_t`
  - `localparam bcd_digit_t BCD_MAX = 4'd9`
- Sub-module `bcd_digit_updown`:
  - Combinational, one per digit, instantiated in a generate loop.
  - Inputs: digit, carry_in, borrow_in.
  - Outputs: next digit, carry_out, borrow_out.
- The top level holds the accumulators, the step decision, the saturate/wrap selection and the count register.

## Test plan

- Reset, then 4 `cw` strobes with NUM_DIGITS=2, PPS=4 → `bcd_count`=0x01 the cycle after the 4th strobe, `step`=01 for one cycle. After only 3 strobes, count is still 0x00.
- Preload to 0x09 via steps, then 4 more `cw` → 0x10. From 0x10, 4 `ccw` → 0x09. Carry and borrow chain correctly across the digit boundary.
- WRAP=0: at 0x99, 4 `cw` → stays 0x99, `step`=01, `at_max`=1. At 0x00, 4 `ccw` → stays 0x00, `at_min`=1.
- WRAP=1, NUM_DIGITS=3: at 0x999, one up step → 0x000. At 0x000, one down step → 0x999.
- 3 `cw` then 1 `ccw` then 3 `cw` → no step. Then a cycle with `cw`=`ccw`=1 → accumulators hold. One more `cw` → up step.
- `clear` asserted together with the completing 4th `cw` → `bcd_count`=0, `step`=00. Async `reset_n` low mid-cycle → outputs take reset values before the next edge.

Source files
------------

// File: rtl/enc_pkg.sv
// Types and constants shared by the encoder-driven BCD counter and its
// digit slices.
package enc_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DN   = 2'b10
  } step_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_updown.sv
// One combinational BCD digit slice. A carry increments the digit and a
// borrow decrements it, with a ripple out at 9->0 or 0->9.
module bcd_digit_updown
  import enc_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       carry_i,
  input  logic       borrow_i,
  output bcd_digit_t digit_o,
  output logic       carry_o,
  output logic       borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    carry_o  = 1'b0;
    borrow_o = 1'b0;
    if (carry_i) begin
      // Using >= folds any corrupt A-F value back to 0 instead of letting it persist.
      if (digit_i >= BCD_MAX) begin
        digit_o = '0;
        carry_o = 1'b1;
      end else begin
        digit_o = digit_i + 4'd1;
      end
    end else if (borrow_i) begin
      if (digit_i == '0) begin
        digit_o  = BCD_MAX;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/enc_bcd_counter.sv
// Rotary-encoder step counter: accumulates cw/ccw strobes per direction and
// steps a packed-BCD count with saturate or wrap at the range limits.
module enc_bcd_counter
  import enc_pkg::*;
#(
  parameter int NUM_DIGITS      = 2,
  parameter int PULSES_PER_STEP = 4,
  parameter int WRAP            = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cw,
  input  logic                    ccw,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] bcd_count,
  output logic [1:0]              step,
  output logic                    at_max,
  output logic                    at_min
);

  localparam int CW       = 4 * NUM_DIGITS;
  localparam int ACC_W    = $clog2(PULSES_PER_STEP + 1);
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(PULSES_PER_STEP - 1);
  localparam logic [CW-1:0]    ALL_NINE = {NUM_DIGITS{BCD_MAX}};

  logic [ACC_W-1:0]  acc_cw_q, acc_cw_d;
  logic [ACC_W-1:0]  acc_ccw_q, acc_ccw_d;
  logic [CW-1:0]     count_q, count_d, count_stepped;
  step_t             step_q, step_d;
  logic [NUM_DIGITS:0] carry, borrow;

  // A reversal discards partial progress; both strobes together are a glitch and hold.
  always_comb begin
    acc_cw_d  = acc_cw_q;
    acc_ccw_d = acc_ccw_q;
    step_d    = STEP_NONE;
    if (clear) begin
      acc_cw_d  = '0;
      acc_ccw_d = '0;
    end else if (cw && !ccw) begin
      acc_ccw_d = '0;
      if (acc_cw_q == ACC_LAST) begin
        acc_cw_d = '0;
        step_d   = STEP_UP;
      end else begin
        acc_cw_d = acc_cw_q + 1'b1;
      end
    end else if (ccw && !cw) begin
      acc_cw_d = '0;
      if (acc_ccw_q == ACC_LAST) begin
        acc_ccw_d = '0;
        step_d    = STEP_DN;
      end else begin
        acc_ccw_d = acc_ccw_q + 1'b1;
      end
    end
  end

  assign carry[0]  = (step_d == STEP_UP);
  assign borrow[0] = (step_d == STEP_DN);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_updown u_digit (
      .digit_i  (count_q[4*g +: 4]),
      .carry_i  (carry[g]),
      .borrow_i (borrow[g]),
      .digit_o  (count_stepped[4*g +: 4]),
      .carry_o  (carry[g+1]),
      .borrow_o (borrow[g+1])
    );
  end

  // The ripple already produces the wrapped value; saturation just refuses it.
  always_comb begin
    count_d = count_stepped;
    if (clear) begin
      count_d = '0;
    end else if ((WRAP == 0) && (carry[NUM_DIGITS] || borrow[NUM_DIGITS])) begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_cw_q  <= '0;
      acc_ccw_q <= '0;
      count_q   <= '0;
      step_q    <= STEP_NONE;
    end else begin
      acc_cw_q  <= acc_cw_d;
      acc_ccw_q <= acc_ccw_d;
      count_q   <= count_d;
      step_q    <= step_d;
    end
  end

  assign bcd_count = count_q;
  assign step      = step_q;
  assign at_max    = (count_q == ALL_NINE);
  assign at_min    = (count_q == '0);

endmodule

// File: tb/tb_enc_bcd_counter.sv
// Bench for enc_bcd_counter: a 2-digit/PPS=4/saturating instance and a
// 3-digit/PPS=1/wrapping instance share stimulus and an integer-value model.
module tb_enc_bcd_counter;

  logic clk = 1'b0;
  logic reset_n, cw, ccw, clear;
  logic [7:0]  count0;
  logic [11:0] count1;
  logic [1:0]  step0, step1;
  logic        max0, min0, max1, min1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enc_bcd_counter #(.NUM_DIGITS(2), .PULSES_PER_STEP(4), .WRAP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .cw(cw), .ccw(ccw), .clear(clear),
    .bcd_count(count0), .step(step0), .at_max(max0), .at_min(min0));

  enc_bcd_counter #(.NUM_DIGITS(3), .PULSES_PER_STEP(1), .WRAP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cw(cw), .ccw(ccw), .clear(clear),
    .bcd_count(count1), .step(step1), .at_max(max1), .at_min(min1));

  // Reference model: count as a plain integer, accumulators as pulse tallies.
  int m_dig [2] = '{2, 3};
  int m_pps [2] = '{4, 1};
  int m_wrap[2] = '{0, 1};
  int m_val [2];
  int m_acw [2];
  int m_accw[2];
  int m_step[2];

  function automatic int range_max(input int digits);
    int r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

  function automatic logic [31:0] to_bcd(input int val, input int digits);
    logic [31:0] r = '0;
    int v = val;
    for (int d = 0; d < digits; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_acw[i] = 0; m_accw[i] = 0; m_step[i] = 0;
    end
  endtask

  task automatic model_update(input logic c, input logic cc, input logic cl);
    for (int i = 0; i < 2; i++) begin
      int mx = range_max(m_dig[i]);
      m_step[i] = 0;
      if (cl) begin
        m_val[i] = 0; m_acw[i] = 0; m_accw[i] = 0;
      end else if (c && !cc) begin
        m_accw[i] = 0;
        m_acw[i]++;
        if (m_acw[i] == m_pps[i]) begin
          m_acw[i] = 0;
          m_step[i] = 1;
          if (m_val[i] == mx) m_val[i] = m_wrap[i] ? 0 : mx;
          else m_val[i]++;
        end
      end else if (cc && !c) begin
        m_acw[i] = 0;
        m_accw[i]++;
        if (m_accw[i] == m_pps[i]) begin
          m_accw[i] = 0;
          m_step[i] = 2;
          if (m_val[i] == 0) m_val[i] = m_wrap[i] ? mx : 0;
          else m_val[i]--;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("d0_count", {24'd0, count0}, to_bcd(m_val[0], 2));
    check("d0_step",  {30'd0, step0},  32'(m_step[0]));
    check("d0_max",   {31'd0, max0},   32'(m_val[0] == 99));
    check("d0_min",   {31'd0, min0},   32'(m_val[0] == 0));
    check("d1_count", {20'd0, count1}, to_bcd(m_val[1], 3));
    check("d1_step",  {30'd0, step1},  32'(m_step[1]));
    check("d1_max",   {31'd0, max1},   32'(m_val[1] == 999));
    check("d1_min",   {31'd0, min1},   32'(m_val[1] == 0));
  endtask

  task automatic apply(input logic c, input logic cc, input logic cl);
    cw = c; ccw = cc; clear = cl;
    @(posedge clk);
    #1;
    model_update(c, cc, cl);
    check_model();
  endtask

  task automatic run(input logic c, input logic cc, input int n);
    for (int k = 0; k < n; k++) apply(c, cc, 1'b0);
  endtask

  typedef struct {
    logic       cw;
    logic       ccw;
    logic       clr;
    logic [7:0] exp_count;
    logic [1:0] exp_step;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'b00};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'b00};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'b00};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h01, 2'b01};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h01, 2'b00};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h01, 2'b00};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h01, 2'b00};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h01, 2'b00};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h01, 2'b00};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h01, 2'b00};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h01, 2'b00};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h01, 2'b00};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h01, 2'b00};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h02, 2'b01};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h02, 2'b00};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h02, 2'b00};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'h02, 2'b00};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 8'h00, 2'b00};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'b00};

    reset_n = 1'b0; cw = 1'b0; ccw = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    check("rst_count0", {24'd0, count0}, 32'h0);
    check("rst_min0",   {31'd0, min0},   32'd1);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].cw, vecs[i].ccw, vecs[i].clr);
      check($sformatf("vec%0d_count", i), {24'd0, count0}, {24'd0, vecs[i].exp_count});
      check($sformatf("vec%0d_step", i),  {30'd0, step0},  {30'd0, vecs[i].exp_step});
    end

    // Carry and borrow across the digit boundary.
    apply(1'b0, 1'b0, 1'b1);
    run(1'b1, 1'b0, 36);
    check("to09", {24'd0, count0}, 32'h09);
    run(1'b1, 1'b0, 4);
    check("carry_10", {24'd0, count0}, 32'h10);
    run(1'b0, 1'b1, 4);
    check("borrow_09", {24'd0, count0}, 32'h09);

    // Saturation at the top and bottom of the 2-digit range.
    run(1'b1, 1'b0, 360);
    check("at99", {24'd0, count0}, 32'h99);
    check("at99_max", {31'd0, max0}, 32'd1);
    run(1'b1, 1'b0, 4);
    check("sat_hi_count", {24'd0, count0}, 32'h99);
    check("sat_hi_step",  {30'd0, step0},  32'd1);
    apply(1'b0, 1'b0, 1'b1);
    check("clr_count1", {20'd0, count1}, 32'h000);
    run(1'b0, 1'b1, 4);
    check("sat_lo_count", {24'd0, count0}, 32'h00);
    check("sat_lo_step",  {30'd0, step0},  32'd2);
    check("sat_lo_min",   {31'd0, min0},   32'd1);

    // Wrap on the 3-digit instance (one strobe per step).
    apply(1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0);
    check("wrap_dn", {20'd0, count1}, 32'h999);
    check("wrap_dn_step", {30'd0, step1}, 32'd2);
    apply(1'b1, 1'b0, 1'b0);
    check("wrap_up", {20'd0, count1}, 32'h000);

    // Randomized direction runs with occasional glitches and clears.
    for (int r = 0; r < 300; r++) begin
      int dir = $urandom_range(0, 2);
      int len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        int p = $urandom_range(0, 99);
        if (p < 2)       apply(1'b1, 1'b0, 1'b1);
        else if (p < 5)  apply(1'b1, 1'b1, 1'b0);
        else if (p < 15) apply(1'b0, 1'b0, 1'b0);
        else             apply(dir == 0, dir == 1, 1'b0);
      end
    end

    // Async reset mid-cycle, then a full step's worth of strobes is needed again.
    apply(1'b0, 1'b0, 1'b1);
    run(1'b1, 1'b0, 6);
    check("pre_rst_count", {24'd0, count0}, 32'h01);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model();
    check("async_count0", {24'd0, count0}, 32'h0);
    check("async_count1", {20'd0, count1}, 32'h0);
    #2;
    reset_n = 1'b1;
    run(1'b1, 1'b0, 3);
    check("post_rst_3", {24'd0, count0}, 32'h00);
    run(1'b1, 1'b0, 1);
    check("post_rst_4", {24'd0, count0}, 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
